dkong_rom_loader: RTL

Sequences the HPS ROM/config download stream for the Donkey Kong family core. It routes index-0 bytes into the main CPU, sound CPU and wave ROM dual-port RAMs and latches the game-variant (mod) byte and DIP bank. It also owns the core reset hold: the game never runs on a partial or invalid image. It sits between hps_io and the ROM dprams / dkong_top.

---
 rtl/dkong_rom_loader.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dkong_rom_loader.sv
// HPS download sequencer for the Donkey Kong core: routes index-0 bytes to the
// CPU/sound/wave ROM rams, latches mod and DIP bytes, and holds core reset until a good image lands.

module dkong_rom_loader #(
  parameter int CPU_SIZE      = 32768,
  parameter int CPU_MIN       = 16384,
  parameter int SND_BASE      = 'hE000,
  parameter int WAV_BASE      = 'h10000,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        I_RESETn,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        cpu_we,
  output logic        snd_we,
  output logic        wav_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [63:0] dip_sw,
  output logic [7:0]  mod_sel,
  output logic [4:0]  mod_flags,
  output logic        core_reset,
  output logic        load_err,
  output logic [15:0] cpu_bytes
);

  localparam int              SND_SIZE    = 4096;
  localparam int              WAV_SIZE    = 65536;
  localparam logic [24:0]     CPU_END     = 25'(CPU_SIZE);
  localparam logic [24:0]     SND_LO      = 25'(SND_BASE);
  localparam logic [24:0]     SND_HI      = 25'(SND_BASE + SND_SIZE);
  localparam logic [24:0]     WAV_LO      = 25'(WAV_BASE);
  localparam logic [24:0]     WAV_HI      = 25'(WAV_BASE + WAV_SIZE);
  localparam logic [16:0]     MIN_BYTES   = 17'(CPU_MIN);
  localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  function automatic logic [4:0] mod_decode(input logic [7:0] sel);
    logic [4:0] flags;
    flags = 5'b00000;
    case (sel)
      8'd0:    flags = 5'b00001;
      8'd1:    flags = 5'b00010;
      8'd2:    flags = 5'b00100;
      8'd3:    flags = 5'b01000;
      8'd4:    flags = 5'b10000;
      default: flags = 5'b00000;
    endcase
    return flags;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dl_q;
  logic          arm_q;
  logic          cpu_we_q, snd_we_q, wav_we_q;
  logic [15:0]   rom_addr_q, rom_addr_d;
  logic [7:0]    rom_data_q, rom_data_d;
  logic [63:0]   dip_q, dip_d;
  logic [7:0]    mod_sel_q, mod_sel_d;
  logic [4:0]    mod_flags_q;
  logic          core_reset_q, core_reset_d;
  logic          load_err_q, load_err_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cpu_bytes_q, cpu_bytes_d;

  logic rise_s, fall_s, start_s, rom_wr_s, img_ok_s;
  logic cpu_hit_s, snd_hit_s, wav_hit_s, stray_s;

  // arm_q blocks a download that was already active when reset released
  assign rise_s   = ioctl_download & ~dl_q & arm_q;
  assign fall_s   = ~ioctl_download & dl_q;
  assign start_s  = rise_s & (ioctl_index == 8'd0) & (state_q != ST_LOADING);
  assign rom_wr_s = ioctl_wr & (ioctl_index == 8'd0) & (state_q == ST_LOADING)
                  & (ioctl_download | dl_q);

  // Address decode and region-relative address for ROM writes
  always_comb begin
    cpu_hit_s  = 1'b0;
    snd_hit_s  = 1'b0;
    wav_hit_s  = 1'b0;
    stray_s    = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    if (rom_wr_s) begin
      if (ioctl_addr < CPU_END) begin
        cpu_hit_s  = 1'b1;
        rom_addr_d = ioctl_addr[15:0];
        rom_data_d = ioctl_dout;
      end else if ((ioctl_addr >= SND_LO) && (ioctl_addr < SND_HI)) begin
        snd_hit_s  = 1'b1;
        rom_addr_d = ioctl_addr[15:0] - SND_LO[15:0];
        rom_data_d = ioctl_dout;
      end else if ((ioctl_addr >= WAV_LO) && (ioctl_addr < WAV_HI)) begin
        wav_hit_s  = 1'b1;
        rom_addr_d = ioctl_addr[15:0] - WAV_LO[15:0];
        rom_data_d = ioctl_dout;
      end else begin
        stray_s = 1'b1;
      end
    end else begin
      stray_s = 1'b0;
    end
  end

  // Byte counter, overflow flag, mod byte and DIP bank next state
  always_comb begin
    cpu_bytes_d = cpu_bytes_q;
    ovf_d       = ovf_q;
    mod_sel_d   = mod_sel_q;
    dip_d       = dip_q;
    if (start_s) begin
      cpu_bytes_d = 16'd0;
      ovf_d       = 1'b0;
    end else begin
      if (cpu_hit_s && (cpu_bytes_q != 16'hFFFF)) begin
        cpu_bytes_d = cpu_bytes_q + 16'd1;
      end else begin
        cpu_bytes_d = cpu_bytes_q;
      end
      if (stray_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
    if (ioctl_download && ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
      mod_sel_d = ioctl_dout;
    end else begin
      mod_sel_d = mod_sel_q;
    end
    if (ioctl_download && ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0)) begin
      dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    end else begin
      dip_d = dip_q;
    end
  end

  // A write landing on the falling-edge cycle still counts toward the image check
  assign img_ok_s = ({1'b0, cpu_bytes_d} >= MIN_BYTES) && !ovf_d;

  // Load sequencer next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start_s) begin
          state_d    = ST_LOADING;
          load_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOADING: begin
        if (fall_s) begin
          if (img_ok_s) begin
            state_d = ST_SETTLE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d    = ST_ERROR;
            load_err_d = 1'b1;
          end
        end else begin
          state_d = ST_LOADING;
        end
      end
      ST_SETTLE: begin
        if (start_s) begin
          state_d    = ST_LOADING;
          load_err_d = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    core_reset_d = (state_d != ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      dl_q         <= 1'b0;
      arm_q        <= 1'b0;
      cpu_we_q     <= 1'b0;
      snd_we_q     <= 1'b0;
      wav_we_q     <= 1'b0;
      rom_addr_q   <= 16'd0;
      rom_data_q   <= 8'd0;
      dip_q        <= 64'd0;
      mod_sel_q    <= 8'd0;
      mod_flags_q  <= 5'b00001;
      core_reset_q <= 1'b1;
      load_err_q   <= 1'b0;
      ovf_q        <= 1'b0;
      cpu_bytes_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_q         <= ioctl_download;
      arm_q        <= arm_q | ~ioctl_download;
      cpu_we_q     <= cpu_hit_s;
      snd_we_q     <= snd_hit_s;
      wav_we_q     <= wav_hit_s;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      dip_q        <= dip_d;
      mod_sel_q    <= mod_sel_d;
      mod_flags_q  <= mod_decode(mod_sel_q);
      core_reset_q <= core_reset_d;
      load_err_q   <= load_err_d;
      ovf_q        <= ovf_d;
      cpu_bytes_q  <= cpu_bytes_d;
    end
  end

  assign cpu_we     = cpu_we_q;
  assign snd_we     = snd_we_q;
  assign wav_we     = wav_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign dip_sw     = dip_q;
  assign mod_sel    = mod_sel_q;
  assign mod_flags  = mod_flags_q;
  assign core_reset = core_reset_q;
  assign load_err   = load_err_q;
  assign cpu_bytes  = cpu_bytes_q;

endmodule
